int_fp_convert: RTL and testbench

Multi-cycle converter from 32/64-bit signed/unsigned integers to IEEE-754 single or double precision. It covers RISC-V fcvt.s.w/wu/l/lu and fcvt.d.w/wu/l/lu, and sits in the FP unit beside the FP-to-integer converter as its reverse path. Rounding follows the RISC-V rm field, and an inexact flag is produced. Valid/ready handshakes are used on both sides; fixed latency is 4 cycles.

---
 rtl/int_fp_convert_pkg.sv | 49 ++++
 rtl/int_fp_convert_if.sv | 28 ++
 rtl/int_fp_convert_leading_zero_count_64.sv | 17 +
 rtl/int_fp_convert.sv | 167 ++++++++++++++++
 tb/tb_int_fp_convert.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/int_fp_convert_pkg.sv
// Shared definitions for the integer-to-floating-point converter: FSM states,
// rounding-mode and operand-format encodings, IEEE-754 bias and mantissa widths.
package int_fp_convert_pkg;

  localparam int DATA_WIDTH = 64;

  localparam int SP_BIAS   = 127;
  localparam int DP_BIAS   = 1023;
  localparam int SP_MANT_W = 23;
  localparam int DP_MANT_W = 52;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ABS  = 3'd1,
    ST_NORM = 3'd2,
    ST_RND  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_t;

  typedef enum logic [1:0] {
    IFMT_S32 = 2'b00,
    IFMT_U32 = 2'b01,
    IFMT_S64 = 2'b10,
    IFMT_U64 = 2'b11
  } ifmt_t;

  // Round-increment decision; encodings 101-111 fall back to RNE.
  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    logic inc;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | s);
      RM_RUP:  inc = ~sign & (g | s);
      RM_RMM:  inc = g;
      default: inc = g & (s | lsb);
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/int_fp_convert_if.sv
// Request/response bundle of the integer-to-FP converter.
// Handshake: a transfer happens on a rising clock edge where the sender's valid
// and the receiver's ready are both high; the sender holds its payload stable
// while valid is high and ready is low.
interface int_fp_convert_if #(
  parameter int DATA_WIDTH = int_fp_convert_pkg::DATA_WIDTH
);
  logic                  in_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [1:0]            in_input_fmt;
  logic                  in_fmt;
  logic [2:0]            in_rm;
  logic                  out_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_flg_NX;

  modport master (
    output in_valid, in_data, in_input_fmt, in_fmt, in_rm, in_ready,
    input  out_ready, out_valid, out_data, out_flg_NX
  );

  modport slave (
    input  in_valid, in_data, in_input_fmt, in_fmt, in_rm, in_ready,
    output out_ready, out_valid, out_data, out_flg_NX
  );
endinterface

// File: rtl/int_fp_convert_leading_zero_count_64.sv
// Combinational 64-bit leading-zero counter with an all-zero flag.
module leading_zero_count_64 (
  input  logic [63:0] value,
  output logic [5:0]  count,
  output logic        all_zero
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (value[i]) count = 6'(63 - i);
    end
    all_zero = (value == 64'd0);
  end

endmodule

// File: rtl/int_fp_convert.sv
// Four-cycle integer (s/u 32/64) to IEEE-754 single/double converter.
// Optional macro INT_FP_NAN_BOX_EN: NaN-box single results (upper word all ones).
module int_fp_convert
  import int_fp_convert_pkg::*;
(
  input  logic            in_clk,
  input  logic            in_rst,
  int_fp_convert_if.slave bus,
  output state_t          dbg_state
);

`ifdef INT_FP_NAN_BOX_EN
  localparam logic [31:0] SP_UPPER = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SP_UPPER = 32'h0000_0000;
`endif

  state_t      state;
  logic [63:0] data_q;
  logic [1:0]  ifmt_q;
  logic        fmt_q;
  logic [2:0]  rm_q;
  logic        sign_q;
  logic [63:0] mag_q;
  logic [63:0] norm_q;
  logic [5:0]  lzc_q;
  logic        zero_q;
  logic        out_ready_q;
  logic        out_valid_q;
  logic [63:0] out_data_q;
  logic        nx_q;

  // Operand extension and magnitude
  logic [63:0] ext_c;
  logic        sign_c;
  logic [63:0] mag_c;

  always_comb begin
    case (ifmt_q)
      IFMT_S32: ext_c = {{32{data_q[31]}}, data_q[31:0]};
      IFMT_U32: ext_c = {32'd0, data_q[31:0]};
      default:  ext_c = data_q;
    endcase
    sign_c = (ifmt_q == IFMT_S32 || ifmt_q == IFMT_S64) ? ext_c[63] : 1'b0;
    mag_c  = sign_c ? (~ext_c + 64'd1) : ext_c;
  end

  logic [5:0] lzc_c;
  logic       zero_c;

  leading_zero_count_64 u_lzc (
    .value    (mag_q),
    .count    (lzc_c),
    .all_zero (zero_c)
  );

  // Rounding of the normalised magnitude; the leading one is implicit.
  logic [SP_MANT_W-1:0] sp_mant;
  logic                 sp_g, sp_s, sp_inc;
  logic [SP_MANT_W:0]   sp_sum;
  logic [DP_MANT_W-1:0] dp_mant;
  logic                 dp_g, dp_s, dp_inc;
  logic [DP_MANT_W:0]   dp_sum;
  logic [10:0]          exp_base;
  logic [10:0]          exp_r;
  logic                 carry;
  logic [63:0]          res_c;
  logic                 nx_c;

  always_comb begin
    sp_mant  = norm_q[62 -: SP_MANT_W];
    sp_g     = norm_q[62 - SP_MANT_W];
    sp_s     = |norm_q[61 - SP_MANT_W:0];
    sp_inc   = round_inc(rm_q, sign_q, sp_mant[0], sp_g, sp_s);
    sp_sum   = {1'b0, sp_mant} + (SP_MANT_W + 1)'(sp_inc);

    dp_mant  = norm_q[62 -: DP_MANT_W];
    dp_g     = norm_q[62 - DP_MANT_W];
    dp_s     = |norm_q[61 - DP_MANT_W:0];
    dp_inc   = round_inc(rm_q, sign_q, dp_mant[0], dp_g, dp_s);
    dp_sum   = {1'b0, dp_mant} + (DP_MANT_W + 1)'(dp_inc);

    exp_base = 11'd63 - {5'd0, lzc_q} + (fmt_q ? 11'(DP_BIAS) : 11'(SP_BIAS));
    carry    = fmt_q ? dp_sum[DP_MANT_W] : sp_sum[SP_MANT_W];
    exp_r    = exp_base + {10'd0, carry};

    // A carry-out leaves the summed mantissa field at zero on its own.
    if (zero_q) begin
      res_c = fmt_q ? 64'd0 : {SP_UPPER, 32'd0};
      nx_c  = 1'b0;
    end else if (fmt_q) begin
      res_c = {sign_q, exp_r, dp_sum[DP_MANT_W-1:0]};
      nx_c  = dp_g | dp_s;
    end else begin
      res_c = {SP_UPPER, sign_q, exp_r[7:0], sp_sum[SP_MANT_W-1:0]};
      nx_c  = sp_g | sp_s;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state       <= ST_IDLE;
      data_q      <= 64'd0;
      ifmt_q      <= 2'd0;
      fmt_q       <= 1'b0;
      rm_q        <= 3'd0;
      sign_q      <= 1'b0;
      mag_q       <= 64'd0;
      norm_q      <= 64'd0;
      lzc_q       <= 6'd0;
      zero_q      <= 1'b0;
      out_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
      nx_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && out_ready_q) begin
            data_q      <= bus.in_data;
            ifmt_q      <= bus.in_input_fmt;
            fmt_q       <= bus.in_fmt;
            rm_q        <= bus.in_rm;
            out_ready_q <= 1'b0;
            state       <= ST_ABS;
          end
        end
        ST_ABS: begin
          sign_q <= sign_c;
          mag_q  <= mag_c;
          state  <= ST_NORM;
        end
        ST_NORM: begin
          norm_q <= mag_q << lzc_c;
          lzc_q  <= lzc_c;
          zero_q <= zero_c;
          state  <= ST_RND;
        end
        ST_RND: begin
          out_data_q  <= res_c;
          nx_q        <= nx_c;
          out_valid_q <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.in_ready) begin
            out_valid_q <= 1'b0;
            out_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          out_ready_q <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_ready  = out_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_flg_NX = nx_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_int_fp_convert.sv
// Directed testbench for int_fp_convert; expected results are hand-computed IEEE-754 encodings.
module tb_int_fp_convert;
  import int_fp_convert_pkg::*;

`ifdef INT_FP_NAN_BOX_EN
  localparam logic [31:0] SP_HI = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SP_HI = 32'h0000_0000;
`endif

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks;
  int     failures;

  int_fp_convert_if #(.DATA_WIDTH(64)) bus ();

  int_fp_convert dut (
    .in_clk    (clk),
    .in_rst    (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one request, returns the first result and its latency in edges (E0 counts as 1).
  task automatic run_op(input logic [63:0] d, input logic [1:0] ifmt, input logic f,
                        input logic [2:0] rm, output logic [63:0] res, output logic nx,
                        output int lat, output logic rdy_after_accept);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid     = 1'b1;
    bus.in_data      = d;
    bus.in_input_fmt = ifmt;
    bus.in_fmt       = f;
    bus.in_rm        = rm;
    @(posedge clk);
    #1;
    bus.in_valid     = 1'b0;
    rdy_after_accept = bus.out_ready;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (bus.out_valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    res = bus.out_data;
    nx  = bus.out_flg_NX;
  endtask

  task automatic ack(output logic rdy, output logic vld);
    bus.in_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_ready = 1'b0;
    rdy = bus.out_ready;
    vld = bus.out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_ready = 1'b0;
    bus.in_data = 64'd0;
    bus.in_input_fmt = 2'd0;
    bus.in_fmt = 1'b0;
    bus.in_rm = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_ready !== 1'b1) begin $display("FAIL reset_ready got=%b exp=1", bus.out_ready); failures++; end
    checks++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", bus.out_valid); failures++; end
    checks++; if (bus.out_data !== 64'd0) begin $display("FAIL reset_data got=%h exp=0", bus.out_data); failures++; end
    checks++; if (bus.out_flg_NX !== 1'b0) begin $display("FAIL reset_nx got=%b exp=0", bus.out_flg_NX); failures++; end
    checks++; if (dbg_state !== ST_IDLE) begin $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); failures++; end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_neg_one_single();
    logic [63:0] res; logic nx, rdy0, rdy, vld; int lat;
    run_op(64'h0000_0000_FFFF_FFFF, IFMT_S32, 1'b0, RM_RNE, res, nx, lat, rdy0);
    checks++; if (rdy0 !== 1'b0) begin $display("FAIL neg1_ready_after_accept got=%b exp=0", rdy0); failures++; end
    checks++; if (lat !== 4) begin $display("FAIL neg1_latency got=%0d exp=4", lat); failures++; end
    checks++; if (res !== {SP_HI, 32'hBF80_0000}) begin $display("FAIL neg1_data got=%h exp=%h", res, {SP_HI, 32'hBF80_0000}); failures++; end
    checks++; if (nx !== 1'b0) begin $display("FAIL neg1_nx got=%b exp=0", nx); failures++; end
    ack(rdy, vld);
    checks++; if (rdy !== 1'b1) begin $display("FAIL neg1_ready_after_ack got=%b exp=1", rdy); failures++; end
    checks++; if (vld !== 1'b0) begin $display("FAIL neg1_valid_after_ack got=%b exp=0", vld); failures++; end
  endtask

  task automatic test_u64_max_double();
    logic [2:0]  rms [2]  = '{RM_RNE, RM_RTZ};
    logic [63:0] exps [2] = '{64'h43F0_0000_0000_0000, 64'h43EF_FFFF_FFFF_FFFF};
    logic [63:0] res; logic nx, rdy0, rdy, vld; int lat;
    for (int k = 0; k < 2; k++) begin
      run_op(64'hFFFF_FFFF_FFFF_FFFF, IFMT_U64, 1'b1, rms[k], res, nx, lat, rdy0);
      checks++; if (lat !== 4) begin $display("FAIL u64max_latency rm=%0d got=%0d exp=4", rms[k], lat); failures++; end
      checks++; if (res !== exps[k]) begin $display("FAIL u64max_data rm=%0d got=%h exp=%h", rms[k], res, exps[k]); failures++; end
      checks++; if (nx !== 1'b1) begin $display("FAIL u64max_nx rm=%0d got=%b exp=1", rms[k], nx); failures++; end
      ack(rdy, vld);
    end
  endtask

  task automatic test_s64_min_double();
    logic [63:0] res; logic nx, rdy0, rdy, vld; int lat;
    run_op(64'h8000_0000_0000_0000, IFMT_S64, 1'b1, RM_RDN, res, nx, lat, rdy0);
    checks++; if (lat !== 4) begin $display("FAIL s64min_latency got=%0d exp=4", lat); failures++; end
    checks++; if (res !== 64'hC3E0_0000_0000_0000) begin $display("FAIL s64min_data got=%h exp=c3e0000000000000", res); failures++; end
    checks++; if (nx !== 1'b0) begin $display("FAIL s64min_nx got=%b exp=0", nx); failures++; end
    ack(rdy, vld);
  endtask

  task automatic test_tie_rounding();
    logic [2:0]  rms [3]  = '{RM_RNE, RM_RUP, RM_RMM};
    logic [31:0] exps [3] = '{32'h4B80_0000, 32'h4B80_0001, 32'h4B80_0001};
    logic [63:0] res; logic nx, rdy0, rdy, vld; int lat;
    for (int k = 0; k < 3; k++) begin
      run_op(64'h0000_0000_0100_0001, IFMT_S32, 1'b0, rms[k], res, nx, lat, rdy0);
      checks++; if (lat !== 4) begin $display("FAIL tie_latency rm=%0d got=%0d exp=4", rms[k], lat); failures++; end
      checks++; if (res !== {SP_HI, exps[k]}) begin $display("FAIL tie_data rm=%0d got=%h exp=%h", rms[k], res, {SP_HI, exps[k]}); failures++; end
      checks++; if (nx !== 1'b1) begin $display("FAIL tie_nx rm=%0d got=%b exp=1", rms[k], nx); failures++; end
      ack(rdy, vld);
    end
  endtask

  task automatic test_zero_stall();
    logic [63:0] res; logic nx, rdy0, rdy, vld; int lat;
    run_op(64'd0, IFMT_S32, 1'b0, RM_RUP, res, nx, lat, rdy0);
    checks++; if (lat !== 4) begin $display("FAIL zero_latency got=%0d exp=4", lat); failures++; end
    checks++; if (res !== {SP_HI, 32'd0}) begin $display("FAIL zero_single_data got=%h exp=%h", res, {SP_HI, 32'd0}); failures++; end
    checks++; if (nx !== 1'b0) begin $display("FAIL zero_single_nx got=%b exp=0", nx); failures++; end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.out_data !== {SP_HI, 32'd0}) begin $display("FAIL stall_data cyc=%0d got=%h exp=%h", c, bus.out_data, {SP_HI, 32'd0}); failures++; end
      checks++; if (bus.out_ready !== 1'b0) begin $display("FAIL stall_ready cyc=%0d got=%b exp=0", c, bus.out_ready); failures++; end
      checks++; if (bus.out_valid !== 1'b1) begin $display("FAIL stall_valid cyc=%0d got=%b exp=1", c, bus.out_valid); failures++; end
    end
    ack(rdy, vld);
    checks++; if (rdy !== 1'b1) begin $display("FAIL stall_ready_after_ack got=%b exp=1", rdy); failures++; end
    run_op(64'd0, IFMT_U64, 1'b1, RM_RDN, res, nx, lat, rdy0);
    checks++; if (res !== 64'd0) begin $display("FAIL zero_double_data got=%h exp=0", res); failures++; end
    checks++; if (nx !== 1'b0) begin $display("FAIL zero_double_nx got=%b exp=0", nx); failures++; end
    ack(rdy, vld);
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] res; logic nx, rdy0, rdy, vld; int lat;
    logic saw_valid;
    @(negedge clk);
    bus.in_valid     = 1'b1;
    bus.in_data      = 64'h0000_0000_0000_007B;
    bus.in_input_fmt = IFMT_U32;
    bus.in_fmt       = 1'b1;
    bus.in_rm        = RM_RNE;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (dbg_state !== ST_NORM) begin $display("FAIL midrst_pre_state got=%0d exp=%0d", dbg_state, ST_NORM); failures++; end
    rst = 1'b1;
    #1;
    checks++; if (dbg_state !== ST_IDLE) begin $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, ST_IDLE); failures++; end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.out_ready !== 1'b1) begin $display("FAIL midrst_ready got=%b exp=1", bus.out_ready); failures++; end
    saw_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) saw_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++; if (saw_valid !== 1'b0) begin $display("FAIL midrst_no_result got=%b exp=0", saw_valid); failures++; end
    run_op(64'd5, IFMT_U32, 1'b1, RM_RNE, res, nx, lat, rdy0);
    checks++; if (lat !== 4) begin $display("FAIL after_rst_latency got=%0d exp=4", lat); failures++; end
    checks++; if (res !== 64'h4014_0000_0000_0000) begin $display("FAIL after_rst_data got=%h exp=4014000000000000", res); failures++; end
    checks++; if (nx !== 1'b0) begin $display("FAIL after_rst_nx got=%b exp=0", nx); failures++; end
    ack(rdy, vld);
  endtask

  // in_ready held high throughout: DONE lasts one cycle and the next request follows.
  task automatic test_back_to_back();
    logic [63:0] res; logic nx, rdy0; int lat;
    bus.in_ready = 1'b1;
    run_op(64'h0000_0000_FFFF_FFF9, IFMT_S32, 1'b0, RM_RNE, res, nx, lat, rdy0);
    checks++; if (lat !== 4) begin $display("FAIL b2b_first_latency got=%0d exp=4", lat); failures++; end
    checks++; if (res !== {SP_HI, 32'hC0E0_0000}) begin $display("FAIL b2b_first_data got=%h exp=%h", res, {SP_HI, 32'hC0E0_0000}); failures++; end
    @(posedge clk);
    #1;
    checks++; if (bus.out_ready !== 1'b1 || bus.out_valid !== 1'b0) begin $display("FAIL b2b_release got=rdy%b/vld%b exp=rdy1/vld0", bus.out_ready, bus.out_valid); failures++; end
    run_op(64'd3, IFMT_U64, 1'b0, RM_RTZ, res, nx, lat, rdy0);
    bus.in_ready = 1'b0;
    checks++; if (lat !== 4) begin $display("FAIL b2b_second_latency got=%0d exp=4", lat); failures++; end
    checks++; if (res !== {SP_HI, 32'h4040_0000}) begin $display("FAIL b2b_second_data got=%h exp=%h", res, {SP_HI, 32'h4040_0000}); failures++; end
    checks++; if (nx !== 1'b0) begin $display("FAIL b2b_second_nx got=%b exp=0", nx); failures++; end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_neg_one_single();
    test_u64_max_double();
    test_s64_min_double();
    test_tie_rounding();
    test_zero_stall();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
